// File: rtl/jt12_arb_pkg.sv
// Purpose: shared types and constants for the jt12 two-requester write scheduler.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package jt12_arb_pkg;

    // FSM encoding for the bus sequencer
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR_WR  = 3'd1,
        ST_ADDR_GAP = 3'd2,
        ST_DATA_WR  = 3'd3,
        ST_DATA_GAP = 3'd4,
        ST_POLL     = 3'd5
    } state_t;

    localparam int PART_W   = 1;
    localparam int REG_W    = 8;
    localparam int DATA_W   = 8;
    localparam int BUSY_BIT = 7;
    // Wide enough for the largest legal BUSY_TIMEOUT
    localparam int CNT_W    = 16;

    typedef struct packed {
        logic [PART_W-1:0] part;
        logic [REG_W-1:0]  rg;
        logic [DATA_W-1:0] dat;
    } wr_txn_t;

    // Extract one requester's payload from the packed request buses
    function automatic wr_txn_t pick_txn(input logic        idx,
                                         input logic [1:0]  part,
                                         input logic [15:0] rg,
                                         input logic [15:0] dat);
        wr_txn_t t;
        t.part = part[idx];
        t.rg   = idx ? rg[15:8]  : rg[7:0];
        t.dat  = idx ? dat[15:8] : dat[7:0];
        return t;
    endfunction

endpackage

// File: rtl/jt12_arb_rr.sv
// Purpose: 2-way round-robin grant with a last-grant pointer (resets to requester 1).
// Latency: grant is combinational from i_req; pointer updates on the i_adv edge.
// Backpressure: none; the grant only takes effect when the caller asserts i_adv.
// Ports: clk, rst_n; i_req[1:0] request vector; i_adv commits the current grant;
//        o_gnt[1:0] one-hot grant (zero when nothing requests).
module jt12_arb_rr (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    input  logic       i_adv,
    output logic [1:0] o_gnt
);

    logic       r_last;
    logic [1:0] w_gnt;

    // On a tie the requester not granted last wins
    always_comb begin
        w_gnt = i_req;
        if (i_req == 2'b11) begin
            w_gnt = r_last ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (i_adv && (|w_gnt)) begin
            r_last <= w_gnt[1];
        end
    end

    assign o_gnt = w_gnt;

endmodule

// File: rtl/jt12_wr_arb.sv
// Purpose: arbitrates two register-write requesters and sequences each write onto the jt12 CPU port.
// Latency: accept pulse in cycle N, first strobe in N+1; 1+2*(WR_PULSE+WR_GAP)+2 cycles per write.
// Backpressure: requesters hold valid until a one-cycle req_ready; nothing is accepted outside IDLE.
// Ports: clk, rst_n (async active-low); i_req_valid/i_req_part/i_req_reg/i_req_data requester side;
//        o_req_ready accept pulse; o_fm_addr/o_fm_din/o_fm_cs_n/o_fm_wr_n/i_fm_dout chip port;
//        o_idle, o_timeout (sticky), i_timeout_clr status.
// Option: JT12_ARB_ADDR_CACHE_EN skips the address phase when {part, reg} repeats.
module jt12_wr_arb
    import jt12_arb_pkg::*;
#(
    parameter int WR_PULSE     = 2,
    parameter int WR_GAP       = 2,
    parameter int BUSY_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  i_req_valid,
    input  logic [1:0]  i_req_part,
    input  logic [15:0] i_req_reg,
    input  logic [15:0] i_req_data,
    output logic [1:0]  o_req_ready,
    output logic [1:0]  o_fm_addr,
    output logic [7:0]  o_fm_din,
    output logic        o_fm_cs_n,
    output logic        o_fm_wr_n,
    input  logic [7:0]  i_fm_dout,
    output logic        o_idle,
    output logic        o_timeout,
    input  logic        i_timeout_clr
);

    localparam logic [CNT_W-1:0] L_PULSE_LAST = CNT_W'(WR_PULSE - 1);
    localparam logic [CNT_W-1:0] L_GAP_LAST   = CNT_W'(WR_GAP - 1);
    localparam logic [CNT_W-1:0] L_POLL_LAST  = CNT_W'(BUSY_TIMEOUT - 1);

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_acc;      // accepted, sequencing starts next cycle
    wr_txn_t          r_txn, w_txn;
    logic [1:0]       r_ready;
    logic [1:0]       r_addr, w_addr_nxt;
    logic [7:0]       r_din, w_din_nxt;
    logic             r_cs_n, w_cs_nxt;
    logic             r_wr_n, w_wr_nxt;
    logic             r_idle;
    logic             r_timeout;
    logic [1:0]       w_gnt;
    logic             w_accept;
    logic             w_poll_exit;
    logic             w_to_set;
    logic             w_hit;
    logic [7:0]       w_unused_dout;

    assign w_unused_dout = i_fm_dout;

    jt12_arb_rr u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .i_req (i_req_valid),
        .i_adv (w_accept),
        .o_gnt (w_gnt)
    );

    assign w_txn = pick_txn(w_gnt[1], i_req_part, i_req_reg, i_req_data);

`ifdef JT12_ARB_ADDR_CACHE_EN
    logic                    r_cache_vld;
    logic [PART_W+REG_W-1:0] r_cache_key;

    assign w_hit = r_cache_vld && (r_cache_key == {r_txn.part, r_txn.rg});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cache_vld <= 1'b0;
            r_cache_key <= '0;
        end else if (w_to_set) begin
            // chip state unknown after a stuck busy: force a fresh address phase
            r_cache_vld <= 1'b0;
        end else if (r_state == ST_IDLE && r_acc && !w_hit) begin
            r_cache_vld <= 1'b1;
            r_cache_key <= {r_txn.part, r_txn.rg};
        end
    end
`else
    assign w_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_acc   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_acc   <= w_accept;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_poll_exit = 1'b0;
        w_to_set    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (r_acc) begin
                    w_state_nxt = w_hit ? ST_DATA_WR : ST_ADDR_WR;
                end
            end
            ST_ADDR_WR: if (r_cnt == L_PULSE_LAST) begin
                w_state_nxt = ST_ADDR_GAP;
                w_cnt_nxt   = '0;
            end
            ST_ADDR_GAP: if (r_cnt == L_GAP_LAST) begin
                w_state_nxt = ST_DATA_WR;
                w_cnt_nxt   = '0;
            end
            ST_DATA_WR: if (r_cnt == L_PULSE_LAST) begin
                w_state_nxt = ST_DATA_GAP;
                w_cnt_nxt   = '0;
            end
            ST_DATA_GAP: if (r_cnt == L_GAP_LAST) begin
                w_state_nxt = ST_POLL;
                w_cnt_nxt   = '0;
            end
            ST_POLL: begin
                // status has one cycle of read latency: the first poll cycle is never trusted
                if (r_cnt != '0 && !i_fm_dout[BUSY_BIT]) begin
                    w_poll_exit = 1'b1;
                end else if (r_cnt == L_POLL_LAST) begin
                    w_poll_exit = 1'b1;
                    w_to_set    = 1'b1;
                end
                if (w_poll_exit) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        // accepting on the POLL exit edge makes the pulse land on the first IDLE cycle
        w_accept = (|i_req_valid) &&
                   ((r_state == ST_IDLE && !r_acc) || w_poll_exit);

        // outputs are registered from the next state so they line up with the state register
        w_addr_nxt = r_addr;
        w_din_nxt  = r_din;
        w_cs_nxt   = 1'b1;
        w_wr_nxt   = 1'b1;
        case (w_state_nxt)
            ST_ADDR_WR: begin
                w_addr_nxt = {r_txn.part, 1'b0};
                w_din_nxt  = r_txn.rg;
                w_cs_nxt   = 1'b0;
                w_wr_nxt   = 1'b0;
            end
            ST_DATA_WR: begin
                w_addr_nxt = {r_txn.part, 1'b1};
                w_din_nxt  = r_txn.dat;
                w_cs_nxt   = 1'b0;
                w_wr_nxt   = 1'b0;
            end
            ST_POLL: begin
                w_addr_nxt = 2'b00;
                w_cs_nxt   = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_txn     <= '0;
            r_ready   <= 2'b00;
            r_addr    <= 2'b00;
            r_din     <= 8'h00;
            r_cs_n    <= 1'b1;
            r_wr_n    <= 1'b1;
            r_idle    <= 1'b1;
            r_timeout <= 1'b0;
        end else begin
            if (w_accept) begin
                r_txn <= w_txn;
            end
            r_ready   <= w_accept ? w_gnt : 2'b00;
            r_addr    <= w_addr_nxt;
            r_din     <= w_din_nxt;
            r_cs_n    <= w_cs_nxt;
            r_wr_n    <= w_wr_nxt;
            r_idle    <= (w_state_nxt == ST_IDLE);
            // a new timeout beats a simultaneous clear
            r_timeout <= w_to_set | (r_timeout & ~i_timeout_clr);
        end
    end

    assign o_req_ready = r_ready;
    assign o_fm_addr   = r_addr;
    assign o_fm_din    = r_din;
    assign o_fm_cs_n   = r_cs_n;
    assign o_fm_wr_n   = r_wr_n;
    assign o_idle      = r_idle;
    assign o_timeout   = r_timeout;

endmodule
